// File: rtl/decode_stage_if.sv
// IF/ID inputs, write-back port and ID/EX outputs of the decode stage.
// The slave side is the decode stage; the master side is the fetch/EX/WB
// environment that feeds it and consumes its results.
interface decode_stage_if;
    // IF/ID pipeline values
    logic [31:0] instruction_dec;
    logic [31:0] pc_next_dec;
    logic [31:0] pc_curr_dec;
    // pipeline control
    logic        flush;
    logic        stall_mem;
    // write-back port
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    // stall back to fetch
    logic        hazard_stall;
    // ID/EX pipeline register
    logic [31:0] rs1_data_ex;
    logic [31:0] rs2_data_ex;
    logic [31:0] imm_ex;
    logic [31:0] pc_ex;
    logic [31:0] pc_next_ex;
    logic [4:0]  rd_ex;
    logic [6:0]  opcode_ex;
    logic [2:0]  funct3_ex;
    logic        funct7b5_ex;
    logic        reg_wr_ex;
    logic        mem_rd_ex;
    logic        mem_wr_ex;
    logic        halt_ex;
    logic        illegal_ex;

    modport master (
        output instruction_dec, pc_next_dec, pc_curr_dec,
        output flush, stall_mem,
        output wb_en, wb_rd, wb_data,
        input  hazard_stall,
        input  rs1_data_ex, rs2_data_ex, imm_ex, pc_ex, pc_next_ex,
        input  rd_ex, opcode_ex, funct3_ex, funct7b5_ex,
        input  reg_wr_ex, mem_rd_ex, mem_wr_ex, halt_ex, illegal_ex
    );

    modport slave (
        input  instruction_dec, pc_next_dec, pc_curr_dec,
        input  flush, stall_mem,
        input  wb_en, wb_rd, wb_data,
        output hazard_stall,
        output rs1_data_ex, rs2_data_ex, imm_ex, pc_ex, pc_next_ex,
        output rd_ex, opcode_ex, funct3_ex, funct7b5_ex,
        output reg_wr_ex, mem_rd_ex, mem_wr_ex, halt_ex, illegal_ex
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: register file with write-through bypass,
// immediate generation, control decode, load-use hazard detection and the
// ID/EX pipeline register. A halt instruction reaching EX parks the stage
// until reset.
module decode_stage #(
    parameter logic [31:0] NOP_INSN  = 32'h0000_0013,
    parameter logic [31:0] HALT_INSN = 32'h0010_0073
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_REG    = 7'h33;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_t;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    typedef struct packed {
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic        halt;
        logic        illegal;
    } idex_t;

    logic [31:0] insn;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    fmt_t        fmt;
    logic [31:0] imm;
    logic        rs1_used;
    logic        rs2_used;
    idex_t       dec;

    logic [31:0] regs [32];
    logic [4:0]  rs_addr [2];
    logic [31:0] rs_val [2];

    idex_t       ex_reg;
    idex_t       ex_next;
    logic        load_en;
    logic        hazard_load;
    logic        hazard_stall;
    state_t      state_reg;
    state_t      state_next;

    // An undriven or corrupted IF/ID word is treated as a harmless NOP.
    assign insn   = $isunknown(bus.instruction_dec) ? NOP_INSN : bus.instruction_dec;
    assign opcode = insn[6:0];
    assign rd     = insn[11:7];

    // Register file write port; x0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
            regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    assign rs_addr[0] = insn[19:15];
    assign rs_addr[1] = insn[24:20];

    // Two read ports, each with a same-cycle bypass of the write-back value.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            assign rs_val[gi] = (rs_addr[gi] == 5'd0) ? 32'd0 :
                                (bus.wb_en && bus.wb_rd == rs_addr[gi]) ? bus.wb_data :
                                regs[rs_addr[gi]];
        end
    endgenerate

    // Classify the opcode into its immediate format.
    always_comb begin
        fmt = FMT_BAD;
        case (opcode)
            OP_REG:                             fmt = FMT_R;
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: fmt = FMT_I;
            OP_STORE:                           fmt = FMT_S;
            OP_BRANCH:                          fmt = FMT_B;
            OP_LUI, OP_AUIPC:                   fmt = FMT_U;
            OP_JAL:                             fmt = FMT_J;
            default:                            fmt = FMT_BAD;
        endcase
    end

    // Immediate generator; every format sign-extends from bit 31.
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{insn[31]}}, insn[31:20]};
            FMT_S:   imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            FMT_B:   imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            FMT_U:   imm = {insn[31:12], 12'd0};
            FMT_J:   imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    // Control decode and the ID/EX candidate value for this instruction.
    always_comb begin
        rs1_used     = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
        rs2_used     = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
        dec          = '0;
        dec.rs1_data = rs_val[0];
        dec.rs2_data = rs_val[1];
        dec.imm      = imm;
        dec.pc       = bus.pc_curr_dec;
        dec.pc_next  = bus.pc_next_dec;
        dec.rd       = rd;
        dec.opcode   = opcode;
        dec.funct3   = insn[14:12];
        dec.funct7b5 = insn[30];
        dec.reg_wr   = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J))
                       && (rd != 5'd0);
        dec.mem_rd   = (opcode == OP_LOAD);
        dec.mem_wr   = (opcode == OP_STORE);
        dec.halt     = (insn == HALT_INSN);
        dec.illegal  = (fmt == FMT_BAD);
    end

    // Load-use: the load in EX targets a register this instruction reads.
    assign hazard_load  = ex_reg.mem_rd && (ex_reg.rd != 5'd0) &&
                          ((rs1_used && rs_addr[0] == ex_reg.rd) ||
                           (rs2_used && rs_addr[1] == ex_reg.rd));
    assign hazard_stall = (state_reg == ST_HALTED) || hazard_load;

    // ID/EX next value: flush beats memory stall, which beats the hazard bubble.
    always_comb begin
        ex_next = ex_reg;
        load_en = 1'b0;
        if (bus.flush) begin
            ex_next = '0;
        end else if (bus.stall_mem) begin
            ex_next = ex_reg;
        end else if (hazard_stall) begin
            ex_next = '0;
        end else begin
            ex_next = dec;
            load_en = 1'b1;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg <= '0;
        end else begin
            ex_reg <= ex_next;
        end
    end

    // Enter HALTED once the halt instruction is actually loaded into EX.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:    if (load_en && dec.halt) state_next = ST_HALTED;
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_RUN;
        endcase
    end

    // Run/halt state register; only reset leaves HALTED.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    assign bus.hazard_stall = hazard_stall;
    assign bus.rs1_data_ex  = ex_reg.rs1_data;
    assign bus.rs2_data_ex  = ex_reg.rs2_data;
    assign bus.imm_ex       = ex_reg.imm;
    assign bus.pc_ex        = ex_reg.pc;
    assign bus.pc_next_ex   = ex_reg.pc_next;
    assign bus.rd_ex        = ex_reg.rd;
    assign bus.opcode_ex    = ex_reg.opcode;
    assign bus.funct3_ex    = ex_reg.funct3;
    assign bus.funct7b5_ex  = ex_reg.funct7b5;
    assign bus.reg_wr_ex    = ex_reg.reg_wr;
    assign bus.mem_rd_ex    = ex_reg.mem_rd;
    assign bus.mem_wr_ex    = ex_reg.mem_wr;
    assign bus.halt_ex      = ex_reg.halt;
    assign bus.illegal_ex   = ex_reg.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios followed by random traffic,
// every cycle compared against an instruction-level reference model.
module tb_decode_stage;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h0010_0073;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if bus ();

    decode_stage #(.NOP_INSN(NOP), .HALT_INSN(HALT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] rs1, rs2, imm, pc, pcn, rd, op, f3, f7, rw, mr, mw, halt, ill;
    } ex_m_t;

    ex_m_t       m;
    logic [31:0] regs_m [32];
    bit          halted_m;
    int          errors = 0;
    int          checks = 0;
    int          txn = 0;
    logic        hz_seen;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic byte fmt_of(logic [6:0] op);
        case (op)
            7'h33:                      return "R";
            7'h03, 7'h13, 7'h67, 7'h73: return "I";
            7'h23:                      return "S";
            7'h63:                      return "B";
            7'h37, 7'h17:               return "U";
            7'h6F:                      return "J";
            default:                    return "X";
        endcase
    endfunction

    // Immediate value as a signed integer, reassembled from the ISA fields.
    function automatic logic [31:0] imm_of(logic [31:0] i);
        int v;
        case (fmt_of(i[6:0]))
            "I": v = $signed(i[31:20]);
            "S": v = $signed({i[31:25], i[11:7]});
            "B": v = $signed({i[31], i[7], i[30:25], i[11:8]}) * 2;
            "U": v = int'(i & 32'hFFFF_F000);
            "J": v = $signed({i[31], i[19:12], i[20], i[30:21]}) * 2;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic bit uses1(logic [31:0] i);
        byte f = fmt_of(i[6:0]);
        return f == "R" || f == "I" || f == "S" || f == "B";
    endfunction

    function automatic bit uses2(logic [31:0] i);
        byte f = fmt_of(i[6:0]);
        return f == "R" || f == "S" || f == "B";
    endfunction

    function automatic logic [31:0] read_reg(logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (bus.wb_en && bus.wb_rd == r) return bus.wb_data;
        return regs_m[r];
    endfunction

    function automatic bit model_hazard();
        logic [31:0] i = bus.instruction_dec;
        if (halted_m) return 1'b1;
        return m.mr != 0 && m.rd != 0 &&
               ((uses1(i) && 32'(i[19:15]) == m.rd) || (uses2(i) && 32'(i[24:20]) == m.rd));
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_edge();
        ex_m_t       d;
        ex_m_t       z;
        logic [31:0] i = bus.instruction_dec;
        byte         f = fmt_of(i[6:0]);
        bit          hz;
        z = '{default: '0};
        if (rst) begin
            m = z;
            halted_m = 1'b0;
            for (int k = 0; k < 32; k++) regs_m[k] = '0;
            return;
        end
        hz    = model_hazard();
        d.rs1 = read_reg(i[19:15]);
        d.rs2 = read_reg(i[24:20]);
        d.imm = imm_of(i);
        d.pc  = bus.pc_curr_dec;
        d.pcn = bus.pc_next_dec;
        d.rd  = 32'(i[11:7]);
        d.op  = 32'(i[6:0]);
        d.f3  = 32'(i[14:12]);
        d.f7  = 32'(i[30]);
        d.rw  = 32'((f == "R" || f == "I" || f == "U" || f == "J") && i[11:7] != 5'd0);
        d.mr  = 32'(i[6:0] == 7'h03);
        d.mw  = 32'(i[6:0] == 7'h23);
        d.halt = 32'(i == HALT);
        d.ill = 32'(f == "X");
        if (bus.flush) m = z;
        else if (bus.stall_mem) m = m;
        else if (hz) m = z;
        else begin
            m = d;
            if (i == HALT) halted_m = 1'b1;
        end
        if (bus.wb_en && bus.wb_rd != 5'd0) regs_m[bus.wb_rd] = bus.wb_data;
    endtask

    task automatic check_ex();
        check("rs1_data_ex", bus.rs1_data_ex, m.rs1);
        check("rs2_data_ex", bus.rs2_data_ex, m.rs2);
        check("imm_ex", bus.imm_ex, m.imm);
        check("pc_ex", bus.pc_ex, m.pc);
        check("pc_next_ex", bus.pc_next_ex, m.pcn);
        check("rd_ex", 32'(bus.rd_ex), m.rd);
        check("opcode_ex", 32'(bus.opcode_ex), m.op);
        check("funct3_ex", 32'(bus.funct3_ex), m.f3);
        check("funct7b5_ex", 32'(bus.funct7b5_ex), m.f7);
        check("reg_wr_ex", 32'(bus.reg_wr_ex), m.rw);
        check("mem_rd_ex", 32'(bus.mem_rd_ex), m.mr);
        check("mem_wr_ex", 32'(bus.mem_wr_ex), m.mw);
        check("halt_ex", 32'(bus.halt_ex), m.halt);
        check("illegal_ex", 32'(bus.illegal_ex), m.ill);
    endtask

    // Apply inputs (called just after a falling edge).
    task automatic drive(logic [31:0] insn, bit fl, bit st, bit we,
                         logic [4:0] wr, logic [31:0] wd, bit r);
        logic [31:0] pc = $urandom & 32'hFFFF_FFFC;
        bus.instruction_dec = insn;
        bus.pc_curr_dec     = pc;
        bus.pc_next_dec     = pc + 32'd4;
        bus.flush           = fl;
        bus.stall_mem       = st;
        bus.wb_en           = we;
        bus.wb_rd           = wr;
        bus.wb_data         = wd;
        rst                 = r;
    endtask

    // One transaction: check the stall, clock, check ID/EX, return to negedge.
    task automatic cycle();
        #1;
        hz_seen = bus.hazard_stall;
        check("hazard_stall", 32'(bus.hazard_stall), 32'(model_hazard()));
        @(posedge clk);
        model_edge();
        #1;
        check_ex();
        $display("txn %0d rst=%b insn=%h flush=%b stall_mem=%b wb=%b x%0d=%h hazard=%b rd_ex=%0d imm_ex=%h halt_ex=%b",
                 txn, rst, bus.instruction_dec, bus.flush, bus.stall_mem, bus.wb_en,
                 bus.wb_rd, bus.wb_data, hz_seen, bus.rd_ex, bus.imm_ex, bus.halt_ex);
        txn++;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_insn();
        logic [6:0]  ops [12] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h73, 7'h23,
                                  7'h63, 7'h37, 7'h17, 7'h6F, 7'h0B, 7'h7F};
        logic [31:0] i = $urandom;
        if ($urandom_range(0, 59) == 0) return HALT;
        i[6:0]   = ops[$urandom_range(0, 11)];
        i[11:7]  = 5'($urandom_range(0, 7));
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        return i;
    endfunction

    initial begin
        logic [31:0] cur;
        m = '{default: '0};
        halted_m = 1'b0;
        for (int k = 0; k < 32; k++) regs_m[k] = '0;
        drive(NOP, 0, 0, 0, 5'd0, 32'd0, 1);
        @(negedge clk);

        // Reset held for two cycles.
        cycle();
        cycle();
        check("reset_hazard", 32'(hz_seen), 32'd0);
        check("reset_rd_ex", 32'(bus.rd_ex), 32'd0);
        check("reset_pc_ex", bus.pc_ex, 32'd0);

        // addi x1,x5,0 reads the cleared x5.
        drive(32'h0002_8093, 0, 0, 0, 5'd0, 32'd0, 0);
        cycle();
        check("x5_after_reset", bus.rs1_data_ex, 32'd0);

        // Write-through bypass: WB x1 alongside addi x2,x1,-1.
        drive(32'hFFF0_8113, 0, 0, 1, 5'd1, 32'h1234_5678, 0);
        cycle();
        check("bypass_rs1", bus.rs1_data_ex, 32'h1234_5678);
        check("bypass_imm", bus.imm_ex, 32'hFFFF_FFFF);
        check("bypass_rd", 32'(bus.rd_ex), 32'd2);
        check("bypass_reg_wr", 32'(bus.reg_wr_ex), 32'd1);

        // Load-use: lw x3,0(x1) then add x4,x3,x2.
        drive(32'h0000_A183, 0, 0, 0, 5'd0, 32'd0, 0);
        cycle();
        drive(32'h0021_8233, 0, 0, 0, 5'd0, 32'd0, 0);
        cycle();
        check("loaduse_stall", 32'(hz_seen), 32'd1);
        check("loaduse_bubble", 32'(bus.reg_wr_ex), 32'd0);
        drive(32'h0021_8233, 0, 0, 1, 5'd3, 32'hCAFE_F00D, 0);
        cycle();
        check("loaduse_release", 32'(hz_seen), 32'd0);
        check("loaduse_rs1", bus.rs1_data_ex, 32'hCAFE_F00D);
        check("loaduse_rd", 32'(bus.rd_ex), 32'd4);

        // Immediate formats.
        drive(32'hFE53_2E23, 0, 0, 0, 5'd0, 32'd0, 0);
        cycle();
        check("sw_imm", bus.imm_ex, 32'hFFFF_FFFC);
        check("sw_mem_wr", 32'(bus.mem_wr_ex), 32'd1);
        check("sw_reg_wr", 32'(bus.reg_wr_ex), 32'd0);
        drive(32'hFE00_0CE3, 0, 0, 0, 5'd0, 32'd0, 0);
        cycle();
        check("beq_imm", bus.imm_ex, 32'hFFFF_FFF8);
        drive(32'hABCD_E3B7, 0, 0, 0, 5'd0, 32'd0, 0);
        cycle();
        check("lui_imm", bus.imm_ex, 32'hABCD_E000);

        // Flush with memory stall loads a bubble.
        drive(32'hFFF0_8113, 1, 1, 0, 5'd0, 32'd0, 0);
        cycle();
        check("flush_rd", 32'(bus.rd_ex), 32'd0);
        check("flush_pc", bus.pc_ex, 32'd0);

        // Memory stall alone holds ID/EX for three cycles.
        drive(32'hABCD_E3B7, 0, 0, 0, 5'd0, 32'd0, 0);
        cycle();
        for (int k = 0; k < 3; k++) begin
            drive(rand_insn(), 0, 1, 0, 5'd0, 32'd0, 0);
            cycle();
            check("stall_hold_imm", bus.imm_ex, 32'hABCD_E000);
            check("stall_hold_rd", 32'(bus.rd_ex), 32'd7);
        end

        // Halt parks the stage until reset.
        drive(HALT, 0, 0, 0, 5'd0, 32'd0, 0);
        cycle();
        check("halt_ex", 32'(bus.halt_ex), 32'd1);
        for (int k = 0; k < 3; k++) begin
            drive(32'hFFF0_8113, 0, 0, 1, 5'd9, 32'h0000_0099, 0);
            cycle();
            check("halted_stall", 32'(hz_seen), 32'd1);
            check("halted_bubble", 32'(bus.reg_wr_ex), 32'd0);
        end
        drive(NOP, 0, 0, 0, 5'd0, 32'd0, 1);
        cycle();
        drive(NOP, 0, 0, 0, 5'd0, 32'd0, 0);
        cycle();
        check("halt_cleared", 32'(hz_seen), 32'd0);

        // Random traffic; fetch holds its instruction while stalled.
        cur = rand_insn();
        for (int n = 0; n < 400; n++) begin
            bit r;
            if (!hz_seen) cur = rand_insn();
            r = halted_m ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) == 0);
            drive(cur, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom, r);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
